// File: rtl/axis_fft_frame_loader.sv
// ============================================================================
// Module      : axis_fft_frame_loader
// Description : AXI-Stream slave front end of the FFT. Packs real/imag beat
//               pairs into {real, imag} words and writes one frame to the FFT
//               input memory. Define FFT_BITREV_ADDR_EN for bit-reversed
//               write addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_fft_frame_loader #(
    parameter int S_TDATA_WDT = 32,
    parameter int VLW_WDT     = 64,
    parameter int S_FIFO_SIZE = 16,
    parameter int ADDR_WDT    = 12,
    parameter int FRAME_LEN   = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [S_TDATA_WDT-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic                   mem_wr_en,
    output logic [ADDR_WDT-1:0]    mem_wr_addr,
    output logic [VLW_WDT-1:0]     mem_wr_data,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   tlast_err
);

    localparam int FPW = $clog2(S_FIFO_SIZE);
    localparam int RXW = ADDR_WDT + 2;
    localparam logic [FPW:0]          c_FIFO_DEPTH = (FPW+1)'(S_FIFO_SIZE);
    localparam logic [RXW-1:0]        c_NUM_BEATS  = RXW'(2 * FRAME_LEN);
    localparam logic [RXW-1:0]        c_LAST_BEAT  = RXW'(2 * FRAME_LEN - 1);
    localparam logic [ADDR_WDT-1:0]   c_LAST_WORD  = ADDR_WDT'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [S_TDATA_WDT-1:0]  r_fifo_mem [S_FIFO_SIZE];
    logic [FPW-1:0]          r_wr_ptr;
    logic [FPW-1:0]          r_rd_ptr;
    logic [FPW:0]            r_fifo_cnt;
    logic [RXW-1:0]          r_rx_cnt;
    logic [ADDR_WDT-1:0]     r_wr_cnt;
    logic [S_TDATA_WDT-1:0]  r_real;
    logic                    r_parity;
    logic                    r_last_wr;
    logic [ADDR_WDT-1:0]     w_addr;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_start_acc;
    logic [S_TDATA_WDT-1:0]  w_pop_data;

    assign s_axis_tready = (r_state == S_LOAD) && (r_fifo_cnt < c_FIFO_DEPTH)
                           && (r_rx_cnt < c_NUM_BEATS);
    assign w_push        = s_axis_tvalid && s_axis_tready;
    assign w_pop         = (r_state == S_LOAD) && (r_fifo_cnt != '0);
    assign w_start_acc   = start && (r_state == S_IDLE);
    assign w_pop_data    = r_fifo_mem[r_rd_ptr];
    assign busy          = (r_state != S_IDLE);
    assign frame_done    = (r_state == S_DONE);

`ifdef FFT_BITREV_ADDR_EN
    // Decimation-in-time input ordering: reverse the word counter bits.
    for (genvar gi = 0; gi < ADDR_WDT; gi++) begin : g_bitrev
        assign w_addr[gi] = r_wr_cnt[ADDR_WDT-1-gi];
    end
`else
    assign w_addr = r_wr_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_LOAD;
            // Leave LOAD in the cycle the final strobe is visible on the port.
            S_LOAD:  if (mem_wr_en && r_last_wr) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
            r_rx_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_real      <= '0;
            r_parity    <= 1'b0;
            r_last_wr   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            tlast_err   <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            if (w_start_acc) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_fifo_cnt <= '0;
                r_rx_cnt   <= '0;
                r_wr_cnt   <= '0;
                r_parity   <= 1'b0;
                r_last_wr  <= 1'b0;
                tlast_err  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_rx_cnt <= r_rx_cnt + 1'b1;
                    if (s_axis_tlast != (r_rx_cnt == c_LAST_BEAT)) begin
                        tlast_err <= 1'b1;
                    end
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_parity <= ~r_parity;
                    if (!r_parity) begin
                        r_real <= w_pop_data;
                    end else begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= w_addr;
                        mem_wr_data <= {r_real, w_pop_data};
                        r_last_wr   <= (r_wr_cnt == c_LAST_WORD);
                        r_wr_cnt    <= r_wr_cnt + 1'b1;
                    end
                end
                if (w_push && !w_pop) begin
                    r_fifo_cnt <= r_fifo_cnt + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_fifo_cnt <= r_fifo_cnt - 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_fft_frame_loader.sv
// ============================================================================
// Module      : tb_axis_fft_frame_loader
// Description : Scoreboard bench for axis_fft_frame_loader (8-word and
//               4096-word instances, random sample data and tvalid gaps).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_fft_frame_loader;

    localparam int AW  = 3;
    localparam int FL  = 8;
    localparam int BAW = 12;
    localparam int BFL = 4096;

    typedef struct {
        int          addr;
        logic [63:0] data;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start, tvalid, tlast, tready, wr_en, busy, frame_done, tlast_err;
    logic [31:0]   tdata;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;

    logic           b_start, b_tvalid, b_tlast, b_tready, b_wr_en, b_busy, b_frame_done, b_tlast_err;
    logic [31:0]    b_tdata;
    logic [BAW-1:0] b_wr_addr;
    logic [63:0]    b_wr_data;

    axis_fft_frame_loader #(.S_TDATA_WDT(32), .VLW_WDT(64), .S_FIFO_SIZE(16),
                            .ADDR_WDT(AW), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .s_axis_tlast(tlast), .mem_wr_en(wr_en), .mem_wr_addr(wr_addr),
        .mem_wr_data(wr_data), .busy(busy), .frame_done(frame_done),
        .tlast_err(tlast_err));

    axis_fft_frame_loader #(.S_TDATA_WDT(32), .VLW_WDT(64), .S_FIFO_SIZE(16),
                            .ADDR_WDT(BAW), .FRAME_LEN(BFL)) dut_big (
        .clk(clk), .rst(rst), .start(b_start),
        .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
        .s_axis_tlast(b_tlast), .mem_wr_en(b_wr_en), .mem_wr_addr(b_wr_addr),
        .mem_wr_data(b_wr_data), .busy(b_busy), .frame_done(b_frame_done),
        .tlast_err(b_tlast_err));

    int   checks = 0;
    int   errors = 0;
    exp_t sq[$];
    exp_t bq[$];
    bit   fd_exp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory address of complex word k in a frame of 2**w words.
    function automatic int order(input int k, input int w);
`ifdef FFT_BITREV_ADDR_EN
        int r = 0;
        for (int b = 0; b < w; b++) begin
            if ((k & (1 << b)) != 0) r = r | (1 << (w - 1 - b));
        end
        return r;
`else
        if (w < 0) return 0;
        return k;
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (frame_done || fd_exp) chk("frame_done", frame_done, fd_exp);
            fd_exp = 1'b0;
            if (wr_en) begin
                if (sq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = sq.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                    fd_exp = e.last;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && b_wr_en) begin
            if (bq.size() == 0) begin
                chk("big_unexpected_write", 1, 0);
            end else begin
                e = bq.pop_front();
                chk("big_wr_addr", b_wr_addr, e.addr);
                chk("big_wr_data", b_wr_data, e.data);
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tready"}, tready, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_tlast_err"}, tlast_err, 0);
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("start_busy", busy, 1);
        chk("start_tlast_err_clear", tlast_err, 0);
    endtask

    // Offers nb beats; tlast is raised on beat tlast_pos (-1: never).
    task automatic send_beats(input int nb, input int tlast_pos, input bit rnd_valid, input bit start_mid);
        int          i = 0;
        int          guard = 0;
        logic [31:0] rv = '0;
        logic [31:0] d;
        d = $urandom;
        while (i < nb && guard < 2000) begin
            @(negedge clk);
            guard++;
            start  = start_mid && (i == 4);
            tvalid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            tdata  = d;
            tlast  = (i == tlast_pos);
            #1;
            if (tvalid && tready) begin
                if (i % 2 == 0) rv = d;
                else sq.push_back('{order(i / 2, AW), {rv, d}, (i == 2 * FL - 1)});
                i++;
                d = $urandom;
            end
        end
        if (i < nb) chk("beat_timeout", i, nb);
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        start  = 1'b0;
    endtask

    task automatic wait_done(input bit exp_err);
        int n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("done_seen", (n < 100), 1);
        chk("busy_in_done", busy, 1);
        chk("tlast_err", tlast_err, exp_err);
        @(negedge clk);
        #2;
        chk("busy_idle", busy, 0);
        chk("queue_empty", sq.size(), 0);
    endtask

    task automatic big_frame();
        int          i = 0;
        int          g = 0;
        logic [31:0] rv = '0;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        while (i < 2 * BFL && g < 20000) begin
            @(negedge clk);
            g++;
            b_tvalid = 1'b1;
            b_tdata  = 32'(i * 7 + 3);
            b_tlast  = (i == 2 * BFL - 1);
            #1;
            if (b_tready) begin
                if (i % 2 == 0) rv = b_tdata;
                else bq.push_back('{order(i / 2, BAW), {rv, b_tdata}, 1'b0});
                i++;
            end
        end
        chk("big_beats", i, 2 * BFL);
        @(negedge clk);
        b_tvalid = 1'b0;
        b_tlast  = 1'b0;
        g = 0;
        while (b_frame_done !== 1'b1 && g < 100) begin
            @(negedge clk);
            #2;
            g++;
        end
        chk("big_done_seen", (g < 100), 1);
        chk("big_tlast_err", b_tlast_err, 0);
        chk("big_queue_empty", bq.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
        b_start = 1'b0; b_tvalid = 1'b0; b_tlast = 1'b0; b_tdata = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        chk("reset_big_busy", b_busy, 0);
        chk("reset_big_tready", b_tready, 0);
        rst = 1'b0;

        // Basic continuous frames, then randomly gapped tvalid.
        start_frame(); send_beats(2 * FL, 2 * FL - 1, 1'b0, 1'b0); wait_done(1'b0);
        for (int k = 0; k < 3; k++) begin
            start_frame(); send_beats(2 * FL, 2 * FL - 1, 1'b1, 1'b0); wait_done(1'b0);
        end

        // Early tlast, then missing tlast; each start clears the flag.
        start_frame(); send_beats(2 * FL, 5, 1'b0, 1'b0); wait_done(1'b1);
        start_frame(); send_beats(2 * FL, -1, 1'b1, 1'b0); wait_done(1'b1);

        // Reset in the middle of a frame.
        start_frame(); send_beats(6, -1, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_outputs_zero("midreset");
        sq.delete();
        fd_exp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        start_frame(); send_beats(2 * FL, 2 * FL - 1, 1'b0, 1'b0); wait_done(1'b0);

        // start during LOAD ignored, then extra beats stall.
        start_frame(); send_beats(2 * FL, 2 * FL - 1, 1'b1, 1'b1); wait_done(1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tvalid = 1'b1;
            tdata  = $urandom;
            #1 chk("overrun_tready", tready, 0);
        end
        @(negedge clk);
        tvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("overrun_no_writes", sq.size(), 0);

        big_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
